wb_write_queue: RTL and testbench
=================================

# wb_write_queue

Write-back queue that drives the register file's write port (`wr_reg`, `wr_data`, `reg_write`) on behalf of result producers such as the ALU and the load unit. It buffers up to DEPTH results in order and retires at most one per cycle. It exposes a per-register pending scoreboard so issue logic can stall on RAW hazards, and optionally forwards the youngest queued value for two read indices.

## Interface
- DEPTH, 4, queue entries; power of 2, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  producer has a result
- in_ready  out  1  queue accepts the result this cycle
- in_reg  in  4  destination register index
- in_data  in  32  result value
- wb_hold  in  1  suppresses retirement this cycle (write port borrowed)
- reg_write  out  1  register-file write enable
- wr_reg  out  4  register-file write index
- wr_data  out  32  register-file write data
- pending  out  16  bit r set while any queued entry targets register r
- fwd_reg1, fwd_reg2  in  4  forwarding lookup indices
- fwd_hit1, fwd_hit2  out  1  lookup matched a queued entry
- fwd_data1, fwd_data2  out  32  data of the youngest matching entry

## Operation
- Circular buffer: wr_ptr, rd_ptr (log2 DEPTH bits), count (log2 DEPTH + 1 bits); pointers wrap modulo DEPTH.
- Push when in_valid && in_ready. A push with in_reg == 0 is accepted but not enqueued: count is unchanged and no write is ever issued.
- Retire: reg_write = (count != 0) && !wb_hold. wr_reg and wr_data come from the head entry; pop on the same edge.
- in_ready = (count < DEPTH) || reg_write. A push into a full queue with a simultaneous pop is legal; count stays DEPTH.
- Simultaneous push and pop on a non-full queue: count is unchanged and both pointers advance.
- pending[r] = OR over valid entries of (entry.reg == r). pending[0] is always 0. The bit clears only after the last entry for r retires; duplicate entries for r are allowed.
- Forwarding: hit when a valid entry has reg == fwd_regN and fwd_regN != 0. Data comes from the youngest such entry. On a miss, data = 0.
- Ordering: writes retire strictly in push order; there is no coalescing.

## Timing
- While rst = 0: in_ready = 0, reg_write = 0, wr_reg = 0, wr_data = 0, pending = 0, fwd_hit* = 0, fwd_data* = 0. Pointers and count are 0 after the edge.
- Latency: an entry pushed at edge N with an empty queue and wb_hold = 0 gives reg_write = 1 during cycle N+1 and is written at edge N+1.
- The write-port outputs, pending and the forwarding outputs are combinational from state (plus wb_hold and fwd_reg*). They have no dependence on in_valid, in_reg or in_data.
- in_ready depends combinationally on wb_hold.
- Reset mid-operation discards all queued entries; no stale writes are issued after reset.
- An entry is visible in pending and forwarding from the cycle after its push edge through its retire cycle inclusive.

## Configuration
- WBQ_FORWARD_EN defined: fwd_* lookup logic is present as described above.
- WBQ_FORWARD_EN undefined: fwd_hit1/2 are tied to 0 and fwd_data1/2 to 0; the ports remain in the interface. Queue and pending behaviour are unchanged.

## Structure
- Shared package holds REG_ADDR_W = 4, DATA_W = 32, NUM_REGS = 16, and the wb_entry_t typedef (reg, data).
- Storage: one array of wb_entry_t plus a per-slot valid vector.
- One sub-module, wbq_match: given the entry array, the valid vector, rd_ptr, count and a lookup index, it returns hit and youngest data. It is instantiated twice, only under WBQ_FORWARD_EN.

## Test plan
- Reset: rst = 0 for 2 cycles with in_valid = 1 -> in_ready = 0, reg_write = 0, pending = 0. After release, in_ready = 1 and count = 0.
- Single write: push r3 = 0xDEADBEEF with wb_hold = 0 -> next cycle reg_write = 1, wr_reg = 3, wr_data = 0xDEADBEEF, pending[3] = 1. The cycle after, reg_write = 0 and pending = 0.
- Hold and fill: wb_hold = 1, push r5 = 1, r5 = 2, r7 = 3, r9 = 4 -> in_ready = 0, pending = 0x02A0. fwd_reg1 = 5 gives hit = 1, data = 2. fwd_reg2 = 0 gives hit = 0. Release hold -> writes retire in order 5/1, 5/2, 7/3, 9/4; pending[5] clears only after the second r5 retires.
- Full with simultaneous pop: queue full, wb_hold = 0, push r2 = 0xA -> in_ready = 1, accepted, count stays 4. r2 = 0xA retires fourth.
- r0 discard: push r0 = 0xFFFF on an empty queue -> accepted, reg_write stays 0, pending = 0, count = 0.
- Reset mid-operation: 3 entries queued under hold, rst = 0 for 1 cycle, then hold = 0 -> no reg_write is ever asserted and pending = 0.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// Shared types and widths for the write-back queue and its forwarding matcher.
package wb_write_queue_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// Producer-side, register-file write-port and forwarding signals of the write-back queue.
interface wb_write_queue_if;
  import wb_write_queue_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0]     in_data;
  logic                  wb_hold;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0]     wr_data;
  logic [NUM_REGS-1:0]   pending;
  logic [REG_ADDR_W-1:0] fwd_reg1;
  logic [REG_ADDR_W-1:0] fwd_reg2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [DATA_W-1:0]     fwd_data1;
  logic [DATA_W-1:0]     fwd_data2;

  modport master (
    output in_valid, in_reg, in_data, wb_hold, fwd_reg1, fwd_reg2,
    input  in_ready, reg_write, wr_reg, wr_data, pending,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_hold, fwd_reg1, fwd_reg2,
    output in_ready, reg_write, wr_reg, wr_data, pending,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/wb_write_queue_match.sv
// Forwarding lookup: combinational, returns data of the youngest valid entry whose index matches.
module wbq_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      slot_vld,
  input  logic [PTR_W-1:0]      rd_ptr,
  input  logic [PTR_W:0]        count,
  input  logic [REG_ADDR_W-1:0] idx,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);
  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if ((PTR_W+1)'(k) < count && slot_vld[slot] &&
          entries[slot].reg_idx == idx && idx != '0) begin
        hit  = 1'b1;
        data = entries[slot].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register-file write port; one retire per cycle, ready when not full or retiring.
// Forwarding lookups are built only when WBQ_FORWARD_EN is defined; otherwise fwd outputs read as 0.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      slot_vld_q, slot_vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic pop;
  logic ready;
  logic push;

  always_comb begin
    pop   = rst && (count_q != '0) && !bus.wb_hold;
    ready = rst && ((count_q < CNT_W'(DEPTH)) || pop);
    // Writes to r0 are accepted and dropped: they never occupy a slot.
    push  = bus.in_valid && ready && (bus.in_reg != '0);

    entries_d  = entries_q;
    slot_vld_d = slot_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    // Pop before push so a full-queue push into the retiring slot keeps its valid bit.
    if (pop) begin
      slot_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      entries_d[wr_ptr_q].reg_idx = bus.in_reg;
      entries_d[wr_ptr_q].data    = bus.in_data;
      slot_vld_d[wr_ptr_q]        = 1'b1;
      wr_ptr_d                    = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      entries_q  <= '0;
      slot_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      entries_q  <= entries_d;
      slot_vld_q <= slot_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    bus.in_ready  = ready;
    bus.reg_write = pop;
    bus.wr_reg    = '0;
    bus.wr_data   = '0;
    if (rst && count_q != '0) begin
      bus.wr_reg  = entries_q[rd_ptr_q].reg_idx;
      bus.wr_data = entries_q[rd_ptr_q].data;
    end
    bus.pending = '0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_vld_q[i]) bus.pending[entries_q[i].reg_idx] = 1'b1;
      end
    end
    bus.pending[0] = 1'b0;
  end

`ifdef WBQ_FORWARD_EN
  logic              hit1, hit2;
  logic [DATA_W-1:0] data1, data2;

  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries_q),
    .slot_vld(slot_vld_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .idx     (bus.fwd_reg1),
    .hit     (hit1),
    .data    (data1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries_q),
    .slot_vld(slot_vld_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .idx     (bus.fwd_reg2),
    .hit     (hit2),
    .data    (data2)
  );

  assign bus.fwd_hit1  = rst && hit1;
  assign bus.fwd_hit2  = rst && hit2;
  assign bus.fwd_data1 = rst ? data1 : '0;
  assign bus.fwd_data2 = rst ? data2 : '0;
`else
  logic unused_fwd;
  assign unused_fwd    = ^{bus.fwd_reg1, bus.fwd_reg2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, single write, hold/fill, full push+pop, r0 drop, mid-run reset.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wb_write_queue_if bus ();

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [3:0] r, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic retire_chk(input string tag, input logic [3:0] r, input logic [31:0] d,
                            input logic [15:0] pend);
    #1;
    chk({tag, "_we"},   32'(bus.reg_write), 32'd1);
    chk({tag, "_reg"},  32'(bus.wr_reg),    32'(r));
    chk({tag, "_data"}, bus.wr_data,        d);
    chk({tag, "_pend"}, 32'(bus.pending),   32'(pend));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_reg   = 4'd1;
    bus.in_data  = 32'h5;
    bus.wb_hold  = 1'b0;
    bus.fwd_reg1 = 4'd0;
    bus.fwd_reg2 = 4'd0;

    // Reset held two cycles with a producer knocking.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_ready", 32'(bus.in_ready),  32'd0);
      chk("rst_we",    32'(bus.reg_write), 32'd0);
      chk("rst_pend",  32'(bus.pending),   32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_count", 32'(dut.count_q),  32'd0);

    // Single write: visible one cycle after the push edge.
    push_entry(4'd3, 32'hDEADBEEF);
    retire_chk("single", 4'd3, 32'hDEADBEEF, 16'h0008);
    #1;
    chk("single_after_we",   32'(bus.reg_write), 32'd0);
    chk("single_after_pend", 32'(bus.pending),   32'd0);

    // Hold and fill.
    bus.wb_hold = 1'b1;
    push_entry(4'd5, 32'd1);
    push_entry(4'd5, 32'd2);
    push_entry(4'd7, 32'd3);
    push_entry(4'd9, 32'd4);
    bus.fwd_reg1 = 4'd5;
    bus.fwd_reg2 = 4'd0;
    #1;
    chk("fill_ready", 32'(bus.in_ready),  32'd0);
    chk("fill_we",    32'(bus.reg_write), 32'd0);
    chk("fill_pend",  32'(bus.pending),   32'h02A0);
    chk("fill_count", 32'(dut.count_q),   32'd4);
`ifdef WBQ_FORWARD_EN
    chk("fwd1_hit",  32'(bus.fwd_hit1), 32'd1);
    chk("fwd1_data", bus.fwd_data1,     32'd2);
`else
    chk("fwd1_hit",  32'(bus.fwd_hit1), 32'd0);
    chk("fwd1_data", bus.fwd_data1,     32'd0);
`endif
    chk("fwd2_r0_hit",  32'(bus.fwd_hit2), 32'd0);
    chk("fwd2_r0_data", bus.fwd_data2,     32'd0);
    bus.fwd_reg2 = 4'd9;
    #1;
`ifdef WBQ_FORWARD_EN
    chk("fwd2_hit",  32'(bus.fwd_hit2), 32'd1);
    chk("fwd2_data", bus.fwd_data2,     32'd4);
`else
    chk("fwd2_hit",  32'(bus.fwd_hit2), 32'd0);
    chk("fwd2_data", bus.fwd_data2,     32'd0);
`endif
    bus.fwd_reg1 = 4'd0;
    bus.fwd_reg2 = 4'd0;

    // Release hold: strict push order, r5 stays pending until its second entry leaves.
    bus.wb_hold = 1'b0;
    retire_chk("drain0", 4'd5, 32'd1, 16'h02A0);
    retire_chk("drain1", 4'd5, 32'd2, 16'h02A0);
    retire_chk("drain2", 4'd7, 32'd3, 16'h0280);
    retire_chk("drain3", 4'd9, 32'd4, 16'h0200);
    #1;
    chk("drain_done_we",   32'(bus.reg_write), 32'd0);
    chk("drain_done_pend", 32'(bus.pending),   32'd0);

    // Full queue with simultaneous pop and push.
    bus.wb_hold = 1'b1;
    push_entry(4'd1, 32'h11);
    push_entry(4'd4, 32'h44);
    push_entry(4'd6, 32'h66);
    push_entry(4'd8, 32'h88);
    bus.wb_hold  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_reg   = 4'd2;
    bus.in_data  = 32'hA;
    #1;
    chk("full_ready",  32'(bus.in_ready),  32'd1);
    chk("full_we",     32'(bus.reg_write), 32'd1);
    chk("full_wr_reg", 32'(bus.wr_reg),    32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("full_count", 32'(dut.count_q), 32'd4);
    retire_chk("fpop0", 4'd4, 32'h44, 16'h0154);
    retire_chk("fpop1", 4'd6, 32'h66, 16'h0144);
    retire_chk("fpop2", 4'd8, 32'h88, 16'h0104);
    retire_chk("fpop3", 4'd2, 32'hA,  16'h0004);
    #1;
    chk("fpop_done_we", 32'(bus.reg_write), 32'd0);

    // r0 writes are accepted and dropped.
    bus.in_valid = 1'b1;
    bus.in_reg   = 4'd0;
    bus.in_data  = 32'hFFFF;
    #1;
    chk("r0_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("r0_we",    32'(bus.reg_write), 32'd0);
    chk("r0_pend",  32'(bus.pending),   32'd0);
    chk("r0_count", 32'(dut.count_q),   32'd0);

    // Reset with entries queued under hold: nothing may retire afterwards.
    bus.wb_hold = 1'b1;
    push_entry(4'd3, 32'h33);
    push_entry(4'd4, 32'h44);
    push_entry(4'd5, 32'h55);
    #1;
    chk("mid_pend_before", 32'(bus.pending), 32'h0038);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_pend",  32'(bus.pending),  32'd0);
    tick();
    rst         = 1'b1;
    bus.wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mid_after_we%0d", i),   32'(bus.reg_write), 32'd0);
      chk($sformatf("mid_after_pend%0d", i), 32'(bus.pending),   32'd0);
      tick();
    end
    chk("mid_after_count", 32'(dut.count_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
